ram_io_responder: RTL

- Memory-side responder for the byte-wide CPU memory bus (mem_a, mem_dout, mem_wr, mem_din, io_buffer_full) that the CPU memory controller drives.
- Serves synchronous byte RAM with fixed 1-cycle read latency.
- Decodes the IO window 0x30000-0x3FFFF: output-byte FIFO with a drain port, a cycle-counter snapshot, and a simulation-end register.
- Used as the system-side model in CPU benches and as the RAM/IO front end in the top level.

---
 rtl/ram_io_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ram_io_responder.sv
// Byte-wide memory responder: 1-cycle RAM plus IO window at 0x30000-0x3FFFF
// holding a TX byte FIFO, a cycle-counter snapshot and an end-of-run register.
module ram_io_responder #(
    parameter int ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        sim_done,
    output logic [7:0]  exit_code,
    output logic        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(FIFO_DEPTH - FULL_MARGIN);

    localparam logic [15:0] OFF_TX   = 16'h0000;
    localparam logic [15:0] OFF_CYC0 = 16'h0004;
    localparam logic [15:0] OFF_CYC1 = 16'h0005;
    localparam logic [15:0] OFF_CYC2 = 16'h0006;
    localparam logic [15:0] OFF_CYC3 = 16'h0007;

    logic [7:0]            r_ram  [0:(2**ADDR_WIDTH)-1];
    logic [7:0]            r_fifo [0:FIFO_DEPTH-1];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic [31:0]           r_cycle;
    logic [31:0]           r_snap;
    logic [7:0]            r_din;
    logic [7:0]            r_exit;
    logic                  r_full;
    logic                  r_done;
    logic                  r_ovf;

    logic                  w_io;
    logic [15:0]           w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_tx_wr;
    logic                  w_end_wr;
    logic                  w_snap_rd;
    logic                  w_ram_wr;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_nonempty;
    logic [CW-1:0]         w_count_nxt;
    logic [7:0]            w_rd_data;
    logic                  w_unused;

    assign w_io       = (mem_a[17:16] == 2'b11);
    assign w_off      = mem_a[15:0];
    assign w_idx      = mem_a[ADDR_WIDTH-1:0];
    assign w_unused   = ^mem_a;

    assign w_tx_wr    = mem_wr && w_io && (w_off == OFF_TX);
    assign w_end_wr   = mem_wr && w_io && (w_off == OFF_CYC0);
    assign w_snap_rd  = !mem_wr && w_io && (w_off == OFF_CYC0);
    assign w_ram_wr   = mem_wr && !w_io;

    // Fullness is judged on the count before any pop in the same cycle.
    assign w_nonempty = (r_count != '0);
    assign w_push     = w_tx_wr && (r_count != DEPTH_C);
    assign w_drop     = w_tx_wr && (r_count == DEPTH_C);
    assign w_pop      = w_nonempty && tx_ready;

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_rd_data = 8'h00;
        if (!w_io) begin
            w_rd_data = r_ram[w_idx];
        end else begin
            unique case (w_off)
                OFF_CYC0: w_rd_data = r_cycle[7:0];
                OFF_CYC1: w_rd_data = r_snap[15:8];
                OFF_CYC2: w_rd_data = r_snap[23:16];
                OFF_CYC3: w_rd_data = r_snap[31:24];
                default:  w_rd_data = 8'h00;
            endcase
        end
    end

    // Storage arrays carry no reset; only control state is cleared.
    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            r_ram[w_idx] <= mem_dout;
        end
        if (w_push) begin
            r_fifo[r_tail] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_din   <= 8'h00;
            r_cycle <= 32'h0;
            r_snap  <= 32'h0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (!mem_wr) begin
                r_din <= w_rd_data;
            end
            if (w_snap_rd) begin
                r_snap <= r_cycle;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt >= THRESH_C);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_done <= 1'b0;
            r_exit <= 8'h00;
        end else if (w_end_wr) begin
            r_done <= 1'b1;
            r_exit <= mem_dout;
        end
    end

    assign mem_din        = r_din;
    assign io_buffer_full = r_full;
    assign tx_valid       = w_nonempty;
    assign tx_data        = w_nonempty ? r_fifo[r_head] : 8'h00;
    assign sim_done       = r_done;
    assign exit_code      = r_exit;
    assign overflow       = r_ovf;

endmodule
